mc_ctrl: RTL

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS-subset control unit.
//   Five-state FSM (FETCH, DCD, EXE, MEM, WB) decoding op/funct into datapath
//   enables and selects. All outputs are combinational in state, op, funct,
//   zero (and mem_rdy when enabled).
// Optional feature macro: CTRL_MEM_WAIT_EN adds input mem_rdy; FETCH and MEM
//   then stall until memory is ready.
// Ports:
//   clk, rst (async, active-low)          clock and reset
//   op, funct, zero                       IR fields and ALU zero flag
//   PCWr, NPCOp, IRWr, RFWr, DMWr         write enables / next-PC select
//   GPRSel, WDSel, EXTOp, ALUOp, BSel     datapath selects
//   illegal                               undecoded instruction pulse in DCD
//   state                                 current FSM state (debug)
module mc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
`ifdef CTRL_MEM_WAIT_EN
  input  logic       mem_rdy,
`endif
  output logic       PCWr,
  output logic [1:0] NPCOp,
  output logic       IRWr,
  output logic       RFWr,
  output logic       DMWr,
  output logic [1:0] GPRSel,
  output logic [1:0] WDSel,
  output logic       EXTOp,
  output logic [2:0] ALUOp,
  output logic       BSel,
  output logic       illegal,
  output logic [2:0] state
);

  localparam int unsigned OPW = 6;
  localparam int unsigned SW_ = 3;

  localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPW-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPW-1:0] OP_LUI   = 6'b001111;
  localparam logic [OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [OPW-1:0] OP_SW    = 6'b101011;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPW-1:0] OP_J     = 6'b000010;
  localparam logic [OPW-1:0] OP_JAL   = 6'b000011;
  localparam logic [OPW-1:0] FN_ADDU  = 6'b100001;
  localparam logic [OPW-1:0] FN_SUBU  = 6'b100011;
  localparam logic [OPW-1:0] FN_JR    = 6'b001000;

  typedef enum logic [SW_-1:0] {
    S_FETCH = 3'b000,
    S_DCD   = 3'b001,
    S_EXE   = 3'b010,
    S_MEM   = 3'b011,
    S_WB    = 3'b100
  } state_t;

  state_t state_q, state_d;
  logic   rdy;

`ifdef CTRL_MEM_WAIT_EN
  assign rdy = mem_rdy;
`else
  assign rdy = 1'b1;
`endif

  // Instruction decode
  logic is_addu, is_subu, is_rtype, is_jr, is_ori, is_lui;
  logic is_lw, is_sw, is_beq, is_j, is_jal, is_legal;

  always_comb begin
    is_addu  = (op == OP_RTYPE) && (funct == FN_ADDU);
    is_subu  = (op == OP_RTYPE) && (funct == FN_SUBU);
    is_rtype = is_addu || is_subu;
    is_jr    = (op == OP_RTYPE) && (funct == FN_JR);
    is_ori   = (op == OP_ORI);
    is_lui   = (op == OP_LUI);
    is_lw    = (op == OP_LW);
    is_sw    = (op == OP_SW);
    is_beq   = (op == OP_BEQ);
    is_j     = (op == OP_J);
    is_jal   = (op == OP_JAL);
    is_legal = is_rtype || is_jr || is_ori || is_lui || is_lw || is_sw ||
               is_beq || is_j || is_jal;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  assign state = state_q;

  // Next-state and output decode
  always_comb begin
    state_d = S_FETCH;
    PCWr    = 1'b0;
    NPCOp   = 2'b00;
    IRWr    = 1'b0;
    RFWr    = 1'b0;
    DMWr    = 1'b0;
    GPRSel  = 2'b00;
    WDSel   = 2'b00;
    EXTOp   = 1'b0;
    ALUOp   = 3'b000;
    BSel    = 1'b0;
    illegal = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        IRWr    = rdy;
        PCWr    = rdy;
        NPCOp   = 2'b00;
        state_d = rdy ? S_DCD : S_FETCH;
      end
      S_DCD: begin
        if (is_j) begin
          PCWr  = 1'b1;
          NPCOp = 2'b10;
        end else if (is_jal) begin
          // Link write and jump share the same edge; WDSel=PC gives PC+4.
          PCWr   = 1'b1;
          NPCOp  = 2'b10;
          RFWr   = 1'b1;
          GPRSel = 2'b10;
          WDSel  = 2'b10;
        end else if (is_jr) begin
          PCWr  = 1'b1;
          NPCOp = 2'b11;
        end else if (is_legal) begin
          state_d = S_EXE;
        end else begin
          illegal = 1'b1;
        end
      end
      S_EXE: begin
        if (is_subu || is_beq) ALUOp = 3'b001;
        else if (is_ori)       ALUOp = 3'b010;
        else if (is_lui)       ALUOp = 3'b011;
        else                   ALUOp = 3'b000;
        BSel  = is_ori || is_lui || is_lw || is_sw;
        EXTOp = is_lw || is_sw || is_beq;
        if (is_beq) begin
          PCWr  = zero;
          NPCOp = 2'b01;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (is_sw) begin
          DMWr    = rdy;
          state_d = rdy ? S_FETCH : S_MEM;
        end else if (is_lw) begin
          state_d = rdy ? S_WB : S_MEM;
        end
      end
      S_WB: begin
        RFWr   = 1'b1;
        GPRSel = is_rtype ? 2'b00 : 2'b01;
        WDSel  = is_lw ? 2'b01 : 2'b00;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset masks every write enable even though FETCH decodes them active.
    if (!rst) begin
      PCWr    = 1'b0;
      IRWr    = 1'b0;
      RFWr    = 1'b0;
      DMWr    = 1'b0;
      illegal = 1'b0;
    end
  end

endmodule
